iir_stream_capture: RTL and testbench

IIR_STREAM_CAPTURE -- requirements
Module: iir_stream_capture

---
 rtl/iir_cap_pkg.sv | 14 +
 rtl/sync_fifo.sv | 67 ++++++
 rtl/iir_stream_capture.sv | 95 +++++++++
 tb/tb_iir_stream_capture.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/iir_cap_pkg.sv
// Shared types and default parameters for the IIR output capture block.
package iir_cap_pkg;

  localparam int W_DEF         = 8;
  localparam int DEPTH_DEF     = 16;
  localparam int FRAME_LEN_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_DONE
  } cap_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered read port and registered status flags.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_req,
  output logic                       rd_en,
  output logic [W-1:0]               dout,
  output logic                       vout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_nxt;
  logic          wr_ok;

  // Reads never bypass: an empty FIFO ignores rd_req even if a write lands now.
  assign rd_en = rd_req && !empty;
  assign wr_ok = wr_en && (!full || rd_en);

  always_comb begin
    level_nxt = level;
    case ({wr_ok, rd_en})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      dout   <= '0;
      vout   <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
        dout   <= mem[rd_ptr];
      end
      vout  <= rd_en;
      level <= level_nxt;
      full  <= (level_nxt == LW'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

endmodule

// File: rtl/iir_stream_capture.sv
// Captures a frame of filter output samples into a FIFO with count, checksum and overflow tracking.
//   state      | meaning
//   ST_IDLE    | waiting for capt_en; samples ignored
//   ST_CAPTURE | accepting samples until frame length or capt_en drops
//   ST_DONE    | frame complete; samples ignored until capt_en drops
module iir_stream_capture
  import iir_cap_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   vin,
  input  logic [W-1:0]           din,
  input  logic                   capt_en,
  input  logic                   rd_req,
  output logic [W-1:0]           dout,
  output logic                   vout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            count,
  output logic [15:0]            chksum,
  output logic                   ovf,
  output logic                   done
);

  cap_state_e  state, state_nxt;
  logic        rd_en;
  logic        capturing;
  logic        accept;
  logic        drop;
  logic [15:0] count_inc;
  logic        frame_last;

  assign capturing  = (state == ST_CAPTURE) && capt_en;
  assign accept     = capturing && vin && (!full || rd_en);
  assign drop       = capturing && vin && full && !rd_en;
  assign count_inc  = count + 16'd1;
  assign frame_last = accept && (count_inc == 16'(FRAME_LEN));
  assign done       = (state == ST_DONE);

  sync_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept),
    .wr_data (din),
    .rd_req  (rd_req),
    .rd_en   (rd_en),
    .dout    (dout),
    .vout    (vout),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (capt_en) state_nxt = ST_CAPTURE;
      ST_CAPTURE: begin
        if (!capt_en)        state_nxt = ST_IDLE;
        else if (frame_last) state_nxt = ST_DONE;
      end
      ST_DONE:    if (!capt_en) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      chksum <= '0;
      ovf    <= 1'b0;
    end else if (state == ST_IDLE && capt_en) begin
      count  <= '0;
      chksum <= '0;
      ovf    <= 1'b0;
    end else begin
      if (accept) begin
        count  <= count_inc;
        chksum <= chksum + 16'(din);
      end
      if (drop) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_iir_stream_capture.sv
// Scoreboard bench for iir_stream_capture: default frame length plus a FRAME_LEN=3 instance.
module tb_iir_stream_capture;

  localparam int W     = 8;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          vin;
  logic [W-1:0]  din;
  logic          capt_en;
  logic          rd_req;
  logic          rd_req_f3;

  logic [W-1:0]  dout,   dout_f3;
  logic          vout,   vout_f3;
  logic          full,   full_f3;
  logic          empty,  empty_f3;
  logic [LW-1:0] level,  level_f3;
  logic [15:0]   count,  count_f3;
  logic [15:0]   chksum, chksum_f3;
  logic          ovf,    ovf_f3;
  logic          done,   done_f3;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] q_exp[$];
  logic [W-1:0] q_f3[$];

  always #5 clk = ~clk;

  iir_stream_capture #(.W(W), .DEPTH(DEPTH), .FRAME_LEN(64)) dut (
    .clk(clk), .rst(rst), .vin(vin), .din(din), .capt_en(capt_en), .rd_req(rd_req),
    .dout(dout), .vout(vout), .full(full), .empty(empty), .level(level),
    .count(count), .chksum(chksum), .ovf(ovf), .done(done)
  );

  iir_stream_capture #(.W(W), .DEPTH(DEPTH), .FRAME_LEN(3)) dut_f3 (
    .clk(clk), .rst(rst), .vin(vin), .din(din), .capt_en(capt_en), .rd_req(rd_req_f3),
    .dout(dout_f3), .vout(vout_f3), .full(full_f3), .empty(empty_f3), .level(level_f3),
    .count(count_f3), .chksum(chksum_f3), .ovf(ovf_f3), .done(done_f3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Readout scoreboards: every VOUT pulse must match the oldest expected sample.
  always @(negedge clk) begin
    if (vout) begin
      if (q_exp.size() == 0) chk("rd_unexpected", 32'(dout), 32'hFFFF_FFFF);
      else                   chk("rd_data", 32'(dout), 32'(q_exp.pop_front()));
    end
    if (vout_f3) begin
      if (q_f3.size() == 0) chk("rd_unexpected_f3", 32'(dout_f3), 32'hFFFF_FFFF);
      else                  chk("rd_data_f3", 32'(dout_f3), 32'(q_f3.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    vin = 1'b0; din = '0; capt_en = 1'b0; rd_req = 1'b0; rd_req_f3 = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    q_exp.delete();
    q_f3.delete();
  endtask

  task automatic start_capture();
    capt_en = 1'b1;
    tick();
  endtask

  task automatic send(input logic [W-1:0] d, input bit push_main, input bit push_f3);
    vin = 1'b1;
    din = d;
    if (push_main) q_exp.push_back(d);
    if (push_f3)   q_f3.push_back(d);
    tick();
    vin = 1'b0;
  endtask

  task automatic read_n(input int n, input bit main_rd, input bit f3_rd);
    rd_req    = main_rd;
    rd_req_f3 = f3_rd;
    repeat (n) tick();
    rd_req    = 1'b0;
    rd_req_f3 = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_level"},  32'(level),  32'd0);
    chk({pfx, "_empty"},  32'(empty),  32'd1);
    chk({pfx, "_full"},   32'(full),   32'd0);
    chk({pfx, "_vout"},   32'(vout),   32'd0);
    chk({pfx, "_dout"},   32'(dout),   32'd0);
    chk({pfx, "_count"},  32'(count),  32'd0);
    chk({pfx, "_chksum"}, 32'(chksum), 32'd0);
    chk({pfx, "_ovf"},    32'(ovf),    32'd0);
    chk({pfx, "_done"},   32'(done),   32'd0);
  endtask

  initial begin
    logic [W-1:0] fill_vals [4];
    fill_vals = '{8'h01, 8'h02, 8'h03, 8'hFF};

    do_reset();
    check_reset_vals("rst");

    // Frame fill, then a CAPT_EN drop with VIN that must be ignored.
    start_capture();
    foreach (fill_vals[i]) send(fill_vals[i], 1'b1, 1'b0);
    chk("fill_count",  32'(count),  32'd4);
    chk("fill_chksum", 32'(chksum), 32'h0105);
    chk("fill_level",  32'(level),  32'd4);
    chk("fill_ovf",    32'(ovf),    32'd0);
    capt_en = 1'b0;
    send(8'h77, 1'b0, 1'b0);
    chk("stop_count", 32'(count), 32'd4);
    chk("stop_level", 32'(level), 32'd4);
    send(8'h78, 1'b0, 1'b0);
    chk("idle_ovf", 32'(ovf), 32'd0);
    read_n(4, 1'b1, 1'b0);
    chk("fill_drain_empty", 32'(empty), 32'd1);
    chk("fill_drain_q", 32'(q_exp.size()), 32'd0);

    // Overflow: 17 samples into a 16-deep buffer.
    do_reset();
    start_capture();
    for (int i = 0; i < 17; i++) send(8'(8'h10 + i), i < 16, 1'b0);
    chk("ovf_full",  32'(full),  32'd1);
    chk("ovf_flag",  32'(ovf),   32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    chk("ovf_level", 32'(level), 32'd16);
    read_n(16, 1'b1, 1'b0);
    chk("ovf_drain_q", 32'(q_exp.size()), 32'd0);
    chk("ovf_drain_empty", 32'(empty), 32'd1);

    // Full with simultaneous read and write.
    do_reset();
    start_capture();
    for (int i = 0; i < 16; i++) send(8'(8'h40 + i), 1'b1, 1'b0);
    chk("rw_full_pre", 32'(full), 32'd1);
    rd_req = 1'b1;
    send(8'hA5, 1'b1, 1'b0);
    rd_req = 1'b0;
    chk("rw_ovf",   32'(ovf),   32'd0);
    chk("rw_level", 32'(level), 32'd16);
    chk("rw_full",  32'(full),  32'd1);
    chk("rw_count", 32'(count), 32'd17);
    read_n(16, 1'b1, 1'b0);
    chk("rw_drain_q", 32'(q_exp.size()), 32'd0);

    // Empty read with simultaneous write: no bypass.
    do_reset();
    start_capture();
    rd_req = 1'b1;
    send(8'h3C, 1'b1, 1'b0);
    rd_req = 1'b0;
    chk("er_vout",  32'(vout),  32'd0);
    chk("er_level", 32'(level), 32'd1);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("er_rd_vout", 32'(vout), 32'd1);
    chk("er_rd_dout", 32'(dout), 32'h3C);
    tick();
    chk("er_vout_pulse", 32'(vout), 32'd0);
    chk("er_dout_hold",  32'(dout), 32'h3C);

    // Frame end on the FRAME_LEN=3 instance.
    do_reset();
    start_capture();
    for (int i = 0; i < 5; i++) begin
      send(8'(8'h21 + i), 1'b1, i < 3);
      if (i == 1) chk("fe_done_early", 32'(done_f3), 32'd0);
      if (i == 2) chk("fe_done_third", 32'(done_f3), 32'd1);
    end
    chk("fe_count",  32'(count_f3),  32'd3);
    chk("fe_chksum", 32'(chksum_f3), 32'h0066);
    chk("fe_level",  32'(level_f3),  32'd3);
    chk("fe_ovf",    32'(ovf_f3),    32'd0);
    chk("fe_done",   32'(done_f3),   32'd1);
    chk("fe_main_count", 32'(count), 32'd5);
    capt_en = 1'b0;
    tick();
    chk("fe_idle_done", 32'(done_f3), 32'd0);
    read_n(5, 1'b1, 1'b1);
    chk("fe_drain_q",    32'(q_exp.size()), 32'd0);
    chk("fe_drain_q_f3", 32'(q_f3.size()),  32'd0);

    // Reset mid-frame with a read pending.
    do_reset();
    start_capture();
    for (int i = 0; i < 5; i++) send(8'(8'h90 + i), 1'b0, 1'b0);
    chk("mr_level", 32'(level), 32'd5);
    chk("mr_count", 32'(count), 32'd5);
    rst = 1'b1;
    rd_req = 1'b1;
    vin = 1'b1;
    tick();
    check_reset_vals("mr");
    idle_inputs();
    rst = 1'b0;
    tick();
    chk("mr_post_empty", 32'(empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
